// File: rtl/pattern_capture_ctrl.sv
// Stimulus/response sequencer for one SUT: LFSR stimulus, settle wait, MISR compaction.
// Optional build macro GOLDEN_CHECK_EN adds golden_sig and a signature compare into pass.
module pattern_capture_ctrl #(
  parameter int         SETTLE = 3,
  parameter int         CNT_W  = 8,
  parameter logic [3:0] SEED   = 4'h1
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pats,
  input  logic             dut_out,
`ifdef GOLDEN_CHECK_EN
  input  logic [7:0]       golden_sig,
`endif
  output logic [3:0]       stim,
  output logic             busy,
  output logic             done,
  output logic [7:0]       signature,
  output logic             pass
);

  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_lfsr;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_pat;
  logic [SW-1:0]    r_settle;
  logic [3:0]       r_stim;
  logic [7:0]       r_sig;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
`ifdef GOLDEN_CHECK_EN
  logic [7:0]       r_golden;
`endif

  logic             w_fb;
  logic [CNT_W-1:0] w_pat_nxt;

  assign w_fb      = r_sig[7] ^ r_sig[5] ^ r_sig[4] ^ r_sig[3] ^ dut_out;
  assign w_pat_nxt = r_pat + 1'b1;

  always_ff @(posedge I1470) begin
    if (I1477) begin
      r_state  <= IDLE;
      r_lfsr   <= SEED;
      r_num    <= '0;
      r_pat    <= '0;
      r_settle <= '0;
      r_stim   <= 4'h0;
      r_sig    <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
`ifdef GOLDEN_CHECK_EN
      r_golden <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_stim <= 4'h0;
          if (start) begin
            r_num  <= num_pats;
            r_sig  <= 8'h00;
            r_pat  <= '0;
            r_lfsr <= SEED;
            r_busy <= 1'b1;
            r_pass <= 1'b0;
`ifdef GOLDEN_CHECK_EN
            r_golden <= golden_sig;
`endif
            r_state <= (num_pats == '0) ? DONE : APPLY;
          end
        end
        APPLY: begin
          r_stim   <= r_lfsr;
          r_settle <= SW'(SETTLE - 1);
          r_state  <= WAIT;
        end
        // settle_cnt runs SETTLE-1 down to 0, one WAIT cycle per value
        WAIT: begin
          if (r_settle == '0) r_state <= CAPTURE;
          else                r_settle <= r_settle - 1'b1;
        end
        CAPTURE: begin
          r_sig   <= {r_sig[6:0], w_fb};
          r_lfsr  <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
          r_pat   <= w_pat_nxt;
          r_state <= (w_pat_nxt == r_num) ? DONE : APPLY;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_stim  <= 4'h0;
          r_busy  <= 1'b0;
`ifdef GOLDEN_CHECK_EN
          r_pass  <= (r_sig == r_golden);
`else
          r_pass  <= 1'b0;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim      = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign pass      = r_pass;

endmodule

// File: tb/tb_pattern_capture_ctrl.sv
// Directed bench for pattern_capture_ctrl: vector table of runs plus reset/golden sequences.
module tb_pattern_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_pats;
  logic       dut_out;
  logic [3:0] stim;
  logic       busy, done, pass;
  logic [7:0] signature;
`ifdef GOLDEN_CHECK_EN
  logic [7:0] golden_sig;
`endif

  int checks   = 0;
  int failures = 0;

  pattern_capture_ctrl #(.SETTLE(3), .CNT_W(8), .SEED(4'h1)) dut (
    .I1470     (clk),
    .I1477     (rst),
    .start     (start),
    .num_pats  (num_pats),
    .dut_out   (dut_out),
`ifdef GOLDEN_CHECK_EN
    .golden_sig(golden_sig),
`endif
    .stim      (stim),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .pass      (pass)
  );

  always #5 clk = ~clk;

  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  typedef struct {
    logic [7:0] n;
    logic       d;
    int         poke;
    logic [7:0] exp_sig;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One run: cyc = posedges from the start edge until done is seen.
  // trace_ok covers stim sequence (each held 5 cycles), busy, and stim=0 at done.
  task automatic run(input logic [7:0] n, input logic d, input int poke,
                     output int cyc, output bit trace_ok);
    trace_ok = 1'b1;
    cyc = 0;
    @(negedge clk);
    num_pats = n; dut_out = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke) begin start = 1'b1; num_pats = 8'd7; end
      else if (cyc == poke + 1) begin start = 1'b0; num_pats = n; end
      if (done) break;
      if (n != 0 && cyc <= int'(n) * 5)
        if (stim !== seq[((cyc - 1) / 5) % 15] || busy !== 1'b1) trace_ok = 1'b0;
    end
    if (!done || stim !== 4'h0) trace_ok = 1'b0;
  endtask

  initial begin
    int cyc;
    bit ok;

    vecs[0] = '{8'd5, 1'b0, -1, 8'h00, 26};
    vecs[1] = '{8'd3, 1'b1, -1, 8'h07, 16};
    vecs[2] = '{8'd1, 1'b0, -1, 8'h00, 6};
    vecs[3] = '{8'd0, 1'b1, -1, 8'h00, 1};
    vecs[4] = '{8'd1, 1'b1, -1, 8'h01, 6};
    vecs[5] = '{8'd8, 1'b1, -1, 8'hF4, 41};
    vecs[6] = '{8'd3, 1'b1,  7, 8'h07, 16};   // restart + num_pats change in WAIT of pattern 2

    rst = 1'b1; start = 1'b0; num_pats = 8'd0; dut_out = 1'b0;
`ifdef GOLDEN_CHECK_EN
    golden_sig = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stim", 32'(stim), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_sig",  32'(signature), 32'h0);
    chk("reset_pass", 32'(pass), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(vecs[i].n, vecs[i].d, vecs[i].poke, cyc, ok);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_sig", i), 32'(signature), 32'(vecs[i].exp_sig));
      chk($sformatf("v%0d_trace", i), 32'(ok), 32'h1);
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_sig_hold", i), 32'(signature), 32'(vecs[i].exp_sig));
    end

    // reset while the third pattern is in CAPTURE
    @(negedge clk);
    num_pats = 8'd5; dut_out = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_reset_stim", 32'(stim), 32'h4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_reset_stim", 32'(stim), 32'h0);
    chk("midrun_reset_busy", 32'(busy), 32'h0);
    chk("midrun_reset_done", 32'(done), 32'h0);
    chk("midrun_reset_sig",  32'(signature), 32'h0);
    run(8'd3, 1'b0, -1, cyc, ok);
    chk("replay_latency", 32'(cyc), 32'd16);
    chk("replay_trace", 32'(ok), 32'h1);
    chk("replay_sig", 32'(signature), 32'h0);

`ifdef GOLDEN_CHECK_EN
    golden_sig = 8'h07;
    run(8'd3, 1'b1, -1, cyc, ok);
    chk("golden_match_pass", 32'(pass), 32'h1);
    @(posedge clk); #1;
    chk("golden_pass_hold", 32'(pass), 32'h1);
    golden_sig = 8'h06;
    run(8'd3, 1'b1, -1, cyc, ok);
    chk("golden_mismatch_pass", 32'(pass), 32'h0);
    chk("golden_mismatch_sig", 32'(signature), 32'h07);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
